load_store_unit: RTL

The load/store unit sits directly downstream of the ALU. It takes the effective address computed by the ALU (`ALU_o` = rs1 + imm) together with the RV32I load/store type and rs2 data. It drives a single-outstanding word-addressed data-memory request with byte enables, then returns aligned and sign- or zero-extended load data, or a fault code, to writeback. Only one access is in flight at a time, under a three-state FSM with an ack-timeout counter.

---
 rtl/load_store_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding data-memory access with byte enables,
// load alignment/extension, fault detection and an ack timeout.
module load_store_unit #(
   parameter int ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        rsp_valid,
   output logic        rsp_wb,
   output logic [4:0]  rsp_rd,
   output logic [31:0] rsp_data,
   output logic [1:0]  rsp_fault,
   output logic [1:0]  fsm_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

   localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

   state_t      state;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic [7:0]  cnt;

   logic        illegal;
   logic        misaligned;
   logic [3:0]  be_n;
   logic [31:0] wdata_n;
   logic [31:0] shifted;
   logic [31:0] ext_data;

   // Handshake: a request transfers on a rising edge where req_valid && req_ready;
   // upstream holds the request stable until then. Responses are never back-pressured.
   assign req_ready = (state == IDLE);
   assign fsm_state = state;

   always_comb begin
      illegal = 1'b0;
      case (req_funct3)
         3'b000, 3'b001, 3'b010: illegal = 1'b0;
         3'b100, 3'b101:         illegal = req_we;
         default:                illegal = 1'b1;
      endcase
      misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      be_n    = 4'b1111;
      wdata_n = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            be_n    = 4'b0001 << req_addr[1:0];
            wdata_n = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            be_n    = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_n = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      shifted  = mem_rdata >> {off_q, 3'b000};
      ext_data = shifted;
      case (f3_q)
         3'b000:  ext_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  ext_data = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  ext_data = {24'd0, shifted[7:0]};
         3'b101:  ext_data = {16'd0, shifted[15:0]};
         default: ext_data = shifted;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         we_q      <= 1'b0;
         f3_q      <= 3'd0;
         off_q     <= 2'd0;
         cnt       <= 8'd0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_be    <= 4'd0;
         mem_wdata <= 32'd0;
         rsp_valid <= 1'b0;
         rsp_wb    <= 1'b0;
         rsp_rd    <= 5'd0;
         rsp_data  <= 32'd0;
         rsp_fault <= 2'b00;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               we_q     <= req_we;
               f3_q     <= req_funct3;
               off_q    <= req_addr[1:0];
               rsp_rd   <= req_rd;
               rsp_data <= 32'd0;
               rsp_wb   <= 1'b0;
               if (illegal || misaligned) begin
                  // Faulting requests never reach memory.
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_fault <= illegal ? 2'b10 : 2'b01;
               end else begin
                  state     <= REQ;
                  cnt       <= 8'd0;
                  mem_req   <= 1'b1;
                  mem_we    <= req_we;
                  mem_addr  <= {req_addr[31:2], 2'b00};
                  mem_be    <= be_n;
                  mem_wdata <= wdata_n;
               end
            end
            REQ: begin
               // An ack on the last counted cycle still completes normally.
               if (mem_ack || (cnt == CNT_LAST)) begin
                  state     <= RESP;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_fault <= mem_ack ? 2'b00 : 2'b11;
                  rsp_wb    <= mem_ack && !we_q;
                  rsp_data  <= (mem_ack && !we_q) ? ext_data : 32'd0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            RESP: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               rsp_wb    <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
